// File: rtl/noc_pkg.sv
// Shared types and the round-robin priority scan for the NoC output-port arbiter.
package noc_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 256;
    localparam int unsigned DEF_MAX_BEATS  = 16;
    localparam int unsigned DEF_SRC_W      = $clog2(DEF_NUM_REQ);
    localparam int unsigned MAX_REQ        = 32;

    typedef logic [DEF_SRC_W-1:0] src_id_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      last;
        src_id_t                   src;
    } beat_t;

    // First set bit of valid at or after ptr, wrapping modulo n (n <= MAX_REQ, ptr < n).
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                            input int unsigned        n,
                                            input int unsigned        ptr);
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (!found && (k < n) && valid[idx[4:0]]) begin
                found   = 1'b1;
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/noc_skid_buffer.sv
// Two-entry output FIFO; space_o is a flop so upstream ready never sees ready_i combinationally.
module noc_skid_buffer #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     push_data_i,
    output logic space_o,
    output logic valid_o,
    output T     data_o,
    input  logic ready_i
);

    T           ent0_q, ent0_d;
    T           ent1_q, ent1_d;
    logic [1:0] vld_q, vld_d;
    logic       space_q;

    // Pop shifts entry 1 to the head, then a push fills the first free slot.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        vld_d  = vld_q;
        if (vld_q[0] && ready_i) begin
            ent0_d = ent1_q;
            vld_d  = {1'b0, vld_q[1]};
        end
        if (push_i) begin
            if (!vld_d[0]) begin
                ent0_d   = push_data_i;
                vld_d[0] = 1'b1;
            end else begin
                ent1_d   = push_data_i;
                vld_d[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            vld_q   <= '0;
            space_q <= 1'b0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            vld_q   <= vld_d;
            space_q <= !vld_d[1];
        end
    end

    assign space_o = space_q;
    assign valid_o = vld_q[0];
    assign data_o  = ent0_q;

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin, packet-locking arbiter sharing one NoC output link between NUM_REQ requesters.
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MAX_BEATS  = DEF_MAX_BEATS,
    parameter int unsigned SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]                   req_last_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    output logic                                 out_valid_o,
    output logic [DATA_WIDTH-1:0]                out_data_o,
    output logic                                 out_last_o,
    output logic [SRC_W-1:0]                     out_src_o,
    input  logic                                 out_ready_i,
    output logic [NUM_REQ-1:0]                   grant_o,
    output logic                                 err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [SRC_W-1:0]      src;
    } arb_beat_t;

    arb_state_e         state_q, state_d;
    logic [SRC_W-1:0]   owner_q, owner_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic               space;
    logic [SRC_W-1:0]   sel;
    logic               sel_any;
    logic               accept;
    logic               last_eff;
    logic [CNT_W-1:0]   cnt_inc;
    arb_beat_t          push_beat;
    arb_beat_t          out_beat;

    // Selection, handshake and lock/release decisions.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        grant_d     = grant_q;
        req_ready_o = '0;

        if (state_q == ARB_LOCKED) begin
            sel     = owner_q;
            sel_any = 1'b1;
        end else begin
            sel     = SRC_W'(rr_pick(MAX_REQ'(req_valid_i), NUM_REQ, 32'(rr_ptr_q)));
            sel_any = |req_valid_i;
        end

        if (sel_any && space) req_ready_o[sel] = 1'b1;
        accept    = req_valid_i[sel] && req_ready_o[sel];
        cnt_inc   = cnt_q + CNT_W'(1);
        last_eff  = req_last_i[sel] || (cnt_inc == CNT_W'(MAX_BEATS));
        push_beat = '{data: req_data_i[sel], last: last_eff, src: sel};

        if (accept) begin
            if (last_eff) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = (sel == SRC_W'(NUM_REQ - 1)) ? '0 : sel + SRC_W'(1);
                cnt_d    = '0;
                grant_d  = '0;
            end else begin
                state_d      = ARB_LOCKED;
                owner_d      = sel;
                cnt_d        = cnt_inc;
                grant_d      = '0;
                grant_d[sel] = 1'b1;
            end
            if (!req_last_i[sel] && last_eff) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            grant_q  <= grant_d;
        end
    end

    noc_skid_buffer #(
        .T(arb_beat_t)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (accept),
        .push_data_i (push_beat),
        .space_o     (space),
        .valid_o     (out_valid_o),
        .data_o      (out_beat),
        .ready_i     (out_ready_i)
    );

    assign out_data_o = out_beat.data;
    assign out_last_o = out_beat.last;
    assign out_src_o  = out_beat.src;
    assign grant_o    = grant_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed bench for noc_rr_arbiter with requester BFMs and an output-beat scoreboard.
module tb_noc_rr_arbiter;
    import noc_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 256;
    localparam int unsigned MB = 4;
    localparam int unsigned SW = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0][DW-1:0]  req_data;
    logic [NR-1:0]          req_last;
    logic [NR-1:0]          req_ready;
    logic                   out_valid;
    logic [DW-1:0]          out_data;
    logic                   out_last;
    logic [SW-1:0]          out_src;
    logic                   out_ready;
    logic [NR-1:0]          grant;
    logic                   err;

    always #5 clk = ~clk;

    noc_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(MB), .SRC_W(SW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
        .out_src_o(out_src), .out_ready_i(out_ready),
        .grant_o(grant), .err_o(err)
    );

    int rem_pkts[NR], pkt_len[NR], beat_idx[NR], sent[NR], exp_seq[NR];
    bit nolast[NR], hold[NR];
    beat_t exp_q[$];
    int errors = 0, checks = 0, cyc = 0, acc_total = 0;
    int first_acc = -1, first_out = -1, last_out = -1;

    function automatic logic [DW-1:0] mk_data(input int g, input int s);
        return DW'({8'(g), 16'(s)});
    endfunction

    task automatic drive();
        for (int g = 0; g < NR; g++) begin
            req_valid[g] = (rem_pkts[g] > 0) && !hold[g];
            req_last[g]  = !nolast[g] && (beat_idx[g] == pkt_len[g] - 1);
            req_data[g]  = mk_data(g, sent[g]);
        end
    endtask

    task automatic apply();
        drive();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic exp_push(input int g, input bit last);
        beat_t b;
        b.src  = SW'(g);
        b.last = last;
        b.data = mk_data(g, exp_seq[g]);
        exp_seq[g]++;
        exp_q.push_back(b);
    endtask

    task automatic bfm_reset();
        for (int g = 0; g < NR; g++) begin
            rem_pkts[g] = 0; pkt_len[g] = 1; beat_idx[g] = 0;
            sent[g] = 0; exp_seq[g] = 0; nolast[g] = 1'b0; hold[g] = 1'b0;
        end
    endtask

    // One clock: sample handshakes before the edge, score output, advance BFMs after it.
    task automatic tick();
        logic [NR-1:0] acc;
        beat_t got, want;
        acc = req_valid & req_ready;
        if (out_valid && out_ready) begin
            got.data = out_data;
            got.last = out_last;
            got.src  = out_src;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL out_unexpected: observed src %0d data %0h expected no beat", out_src, out_data[23:0]);
            end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                checks++;
                assert (got === want) else begin
                    errors++;
                    $error("FAIL out_beat: observed src %0d last %0b data %0h expected src %0d last %0b data %0h",
                           got.src, got.last, got.data[23:0], want.src, want.last, want.data[23:0]);
                end
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        if (acc != '0) begin
            acc_total++;
            if (first_acc < 0) first_acc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int g = 0; g < NR; g++) begin
            if (acc[g]) begin
                sent[g]++;
                beat_idx[g]++;
                if (beat_idx[g] == pkt_len[g]) begin
                    beat_idx[g] = 0;
                    rem_pkts[g]--;
                end
            end
        end
        drive();
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (exp_q.size() != 0 || req_valid != '0); i++) tick();
        tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_grant(input logic [NR-1:0] g);
        for (int i = 0; i < 20 && grant !== g; i++) tick();
        chk("wait_grant", 64'(grant), 64'(g));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        bfm_reset();
        drive();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data != '0), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // All four requesters with single-beat packets: strict rotation, one beat per cycle.
        for (int g = 0; g < NR; g++) begin rem_pkts[g] = 2; pkt_len[g] = 1; end
        for (int r = 0; r < 2; r++) for (int g = 0; g < NR; g++) exp_push(g, 1'b1);
        first_acc = -1; first_out = -1; last_out = -1;
        apply();
        drain();
        chk("first_latency", 64'(first_out - first_acc), 64'd1);
        chk("throughput_span", 64'(last_out - first_out), 64'd7);

        // Requester 1 three-beat packet while requester 2 waits.
        rem_pkts[1] = 1; pkt_len[1] = 3;
        rem_pkts[2] = 1; pkt_len[2] = 1;
        exp_push(1, 1'b0); exp_push(1, 1'b0); exp_push(1, 1'b1); exp_push(2, 1'b1);
        apply();
        chk("t2_idle_ready", 64'(req_ready), 64'h2);
        chk("t2_idle_grant", 64'(grant), 64'h0);
        tick();
        chk("t2_lock_grant_a", 64'(grant), 64'h2);
        chk("t2_lock_ready_a", 64'(req_ready), 64'h2);
        tick();
        chk("t2_lock_grant_b", 64'(grant), 64'h2);
        chk("t2_lock_ready_b", 64'(req_ready), 64'h2);
        tick();
        chk("t2_release_grant", 64'(grant), 64'h0);
        chk("t2_release_ready", 64'(req_ready), 64'h4);
        drain();

        // Owner 0 stalls mid-packet; requester 3 must wait for the last beat.
        rem_pkts[0] = 1; pkt_len[0] = 3;
        exp_push(0, 1'b0); exp_push(0, 1'b0); exp_push(0, 1'b1); exp_push(3, 1'b1);
        apply();
        chk("t3_idle_ready", 64'(req_ready), 64'h1);
        tick();
        rem_pkts[3] = 1; pkt_len[3] = 1;
        apply();
        chk("t3_lock_grant", 64'(grant), 64'h1);
        tick();
        hold[0] = 1'b1;
        apply();
        for (int i = 0; i < 5; i++) begin
            chk("t3_gap_grant", 64'(grant), 64'h1);
            chk("t3_gap_ready3", 64'(req_ready[3]), 64'd0);
            tick();
        end
        hold[0] = 1'b0;
        apply();
        tick();
        chk("t3_release_grant", 64'(grant), 64'h0);
        drain();

        // Downstream stall: only two beats may be absorbed.
        out_ready = 1'b0;
        rem_pkts[1] = 3; pkt_len[1] = 1;
        rem_pkts[2] = 3; pkt_len[2] = 1;
        for (int r = 0; r < 3; r++) begin exp_push(1, 1'b1); exp_push(2, 1'b1); end
        a0 = acc_total;
        apply();
        tick(); tick();
        chk("t4_full_valid", 64'(out_valid), 64'd1);
        chk("t4_full_ready", 64'(req_ready), 64'd0);
        tick(); tick();
        chk("t4_stall_ready", 64'(req_ready), 64'd0);
        chk("t4_stall_accepts", 64'(acc_total - a0), 64'd2);
        out_ready = 1'b1;
        apply();
        drain();

        // Requester 2 overruns MAX_BEATS: forced last, sticky error, pointer moves to 3.
        chk("t5_err_before", 64'(err), 64'd0);
        rem_pkts[2] = 1; pkt_len[2] = 6; nolast[2] = 1'b1;
        exp_push(2, 1'b0); exp_push(2, 1'b0); exp_push(2, 1'b0); exp_push(2, 1'b1);
        exp_push(3, 1'b1); exp_push(1, 1'b1); exp_push(2, 1'b0); exp_push(2, 1'b0);
        apply();
        wait_grant(4'b0100);
        rem_pkts[1] = 1; pkt_len[1] = 1;
        rem_pkts[3] = 1; pkt_len[3] = 1;
        apply();
        drain();
        chk("t5_err_sticky", 64'(err), 64'd1);

        // Reset with a full buffer mid-packet discards everything.
        out_ready = 1'b0;
        rem_pkts[2] = 1; pkt_len[2] = 3;
        apply();
        tick(); tick();
        chk("t6_full_valid", 64'(out_valid), 64'd1);
        chk("t6_full_ready", 64'(req_ready), 64'd0);
        chk("t6_err_held", 64'(err), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_data", 64'(out_data != '0), 64'd0);
        chk("t6_rst_last", 64'(out_last), 64'd0);
        chk("t6_rst_src", 64'(out_src), 64'd0);
        chk("t6_rst_grant", 64'(grant), 64'd0);
        chk("t6_rst_ready", 64'(req_ready), 64'd0);
        chk("t6_rst_err", 64'(err), 64'd0);
        bfm_reset();
        exp_q.delete();
        out_ready = 1'b1;
        apply();
        tick(); tick();
        rst_n = 1'b1;
        for (int g = 0; g < NR; g++) begin rem_pkts[g] = 1; pkt_len[g] = 1; exp_push(g, 1'b1); end
        apply();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
